// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Releases STAGES reset domains one at a time, lowest index first.
//            Each release waits for the previous domain to report ready and
//            then for a GAP-cycle settling delay. After release, readiness is
//            supervised: a released domain that loses ready causes every
//            domain from it upward to be re-reset and re-sequenced; a domain
//            that fails to come ready within TIMEOUT cycles latches fault.
// Ports    : clk          in   clock, all state changes on posedge
//            reset_in     in   asynchronous active-high reset
//            stage_ready  in   [STAGES] per-domain ready
//            reset_out    out  [STAGES] per-domain reset, active-high
//            stage        out  [STG_W] index of domain being sequenced
//            done         out  all domains released and ready
//            fault        out  sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int STAGES  = 4,
  parameter int GAP     = 3,
  parameter int TIMEOUT = 1023,
  localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] reset_out,
  output logic [STG_W-1:0]  stage,
  output logic              done,
  output logic              fault
);

  localparam int MAXC  = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CNT_W = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

  localparam logic [1:0] S_SETTLE = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [CNT_W-1:0]  C_GAP     = CNT_W'(GAP);
  localparam logic [CNT_W-1:0]  C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [STG_W-1:0]  C_LAST    = STG_W'(STAGES - 1);
  localparam logic [STAGES-1:0] C_ONES    = {STAGES{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [STAGES-1:0] reset_out_q, reset_out_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  // Domains currently considered released for loss-of-ready supervision.
  // The domain being waited on is excluded: its failure to come ready is
  // handled by the timeout, not by re-sequencing. Supervision is off in FAULT.
  logic [STAGES-1:0] released;
  logic              lost_vld;
  logic [STG_W-1:0]  lost_idx;

  for (genvar i = 0; i < STAGES; i++) begin : g_released
    assign released[i] = (state_q == S_RUN) ||
                         (((state_q == S_SETTLE) || (state_q == S_WAIT)) &&
                          (STG_W'(i) < stage_q));
  end

  // Lowest released domain that dropped ready; scanned high-to-low so the
  // final assignment wins with the lowest index.
  always_comb begin
    lost_vld = 1'b0;
    lost_idx = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (released[i] && !stage_ready[i]) begin
        lost_vld = 1'b1;
        lost_idx = STG_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    reset_out_d = reset_out_q;
    done_d      = done_q;
    fault_d     = fault_q;

    case (state_q)
      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          reset_out_d[stage_q] = 1'b0;
          cnt_d                = C_TIMEOUT;
          state_d              = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stage_ready[stage_q]) begin
          if (stage_q == C_LAST) begin
            done_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            stage_d = stage_q + 1'b1;
            cnt_d   = C_GAP;
            state_d = S_SETTLE;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Re-reset the stalled domain and everything above it.
          reset_out_d = reset_out_q | (C_ONES << stage_q);
          fault_d     = 1'b1;
          state_d     = S_FAULT;
        end
      end
      default: begin
        // S_RUN and S_FAULT hold their state.
      end
    endcase

    // Loss of ready takes priority over the normal transition above.
    if (lost_vld) begin
      reset_out_d = reset_out_q | (C_ONES << lost_idx);
      stage_d     = lost_idx;
      cnt_d       = C_GAP;
      done_d      = 1'b0;
      state_d     = S_SETTLE;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= S_SETTLE;
      cnt_q       <= C_GAP;
      stage_q     <= '0;
      reset_out_q <= C_ONES;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      reset_out_q <= reset_out_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign reset_out = reset_out_q;
  assign stage     = stage_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. Directed scenarios plus
//            randomized ready patterns, compared against a timestamp-based
//            reference model that tracks how many domains are released and
//            the edge number at which the next release or timeout is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int STAGES  = 4;
  localparam int GAP     = 3;
  localparam int TIMEOUT = 7;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [3:0] stage_ready;
  logic [3:0] reset_out;
  logic [1:0] stage;
  logic       done;
  logic       fault;

  logic [3:0] g0_reset_out;
  logic [1:0] g0_stage;
  logic       g0_done;
  logic       g0_fault;

  reset_sequencer #(.STAGES(STAGES), .GAP(GAP), .TIMEOUT(TIMEOUT)) u_dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .stage_ready(stage_ready),
    .reset_out  (reset_out),
    .stage      (stage),
    .done       (done),
    .fault      (fault)
  );

  // Zero-gap instance, ready tied high.
  reset_sequencer #(.STAGES(4), .GAP(0), .TIMEOUT(7)) u_dut_g0 (
    .clk        (clk),
    .reset_in   (reset_in),
    .stage_ready(4'hF),
    .reset_out  (g0_reset_out),
    .stage      (g0_stage),
    .done       (g0_done),
    .fault      (g0_fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: edges since reset release, number of released
  // domains (from index 0 upward), domain being sequenced, and the edge on
  // which the pending release (settling) or timeout (waiting) falls due.
  int m_n, m_rel, m_stage, m_deadline;
  bit m_done, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n        = 0;
    m_rel      = 0;
    m_stage    = 0;
    m_deadline = GAP + 1;
    m_done     = 0;
    m_fault    = 0;
  endtask

  task automatic model_edge(input logic [3:0] rdy);
    int lim, lost;
    m_n++;
    if (m_fault) return;
    lim  = m_done ? STAGES : m_stage;
    lost = -1;
    for (int j = 0; j < lim; j++)
      if (!rdy[j] && lost < 0) lost = j;
    if (lost >= 0) begin
      m_rel      = lost;
      m_stage    = lost;
      m_done     = 0;
      m_deadline = m_n + GAP + 1;
      return;
    end
    if (m_done) return;
    if (m_rel == m_stage) begin
      if (m_n == m_deadline) begin
        m_rel++;
        m_deadline = m_n + TIMEOUT + 1;
      end
    end else begin
      if (rdy[m_stage]) begin
        if (m_stage == STAGES - 1) m_done = 1;
        else begin
          m_stage++;
          m_deadline = m_n + GAP + 1;
        end
      end else if (m_n == m_deadline) begin
        m_fault = 1;
        m_rel   = m_stage;
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_ro;
    exp_ro = 4'hF << m_rel;
    chk("model_reset_out", {28'd0, reset_out}, {28'd0, exp_ro});
    chk("model_stage",     {30'd0, stage},     32'(m_stage));
    chk("model_done",      {31'd0, done},      32'(m_done));
    chk("model_fault",     {31'd0, fault},     32'(m_fault));
  endtask

  // Drive ready, take one edge, then compare away from the edge.
  task automatic step(input logic [3:0] rdy);
    stage_ready = rdy;
    @(posedge clk);
    model_edge(rdy);
    #1;
    check_model();
  endtask

  // Asynchronous reset pulse confined to the low clock phase.
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset_in = 1'b1;
    #1;
    chk("async_reset_out", {28'd0, reset_out}, 32'hF);
    chk("async_stage",     {30'd0, stage},     32'd0);
    chk("async_done",      {31'd0, done},      32'd0);
    chk("async_fault",     {31'd0, fault},     32'd0);
    #1 reset_in = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] g0_exp;
    int         g0_rel;
    int         stuck_bit, stuck_left;

    reset_in    = 1'b1;
    stage_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reset_out", {28'd0, reset_out}, 32'hF);
    chk("rst_stage",     {30'd0, stage},     32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_fault",     {31'd0, fault},     32'd0);
    @(negedge clk);
    reset_in = 1'b0;
    model_reset();

    // Ready high everywhere: fixed release schedule, plus zero-gap instance.
    for (int n = 1; n <= 20; n++) begin
      step(4'hF);
      case (n)
        4:  chk("t1_e4_reset_out",  {28'd0, reset_out}, 32'hE);
        9:  chk("t1_e9_reset_out",  {28'd0, reset_out}, 32'hC);
        14: chk("t1_e14_reset_out", {28'd0, reset_out}, 32'h8);
        19: begin
          chk("t1_e19_reset_out", {28'd0, reset_out}, 32'h0);
          chk("t1_e19_done",      {31'd0, done},      32'd0);
        end
        20: chk("t1_e20_done", {31'd0, done}, 32'd1);
        default: ;
      endcase
      g0_rel = 0;
      for (int k = 0; k < 4; k++)
        if (2 * k + 1 <= n) g0_rel++;
      g0_exp = 4'hF << g0_rel;
      chk("g0_reset_out", {28'd0, g0_reset_out}, {28'd0, g0_exp});
      chk("g0_done",      {31'd0, g0_done},      (n >= 8) ? 32'd1 : 32'd0);
    end

    // Timeout on domain 1.
    pulse_reset();
    for (int n = 1; n <= 22; n++) begin
      step(4'b1101);
      case (n)
        9:  chk("t3_e9_reset_out",  {28'd0, reset_out}, 32'hC);
        16: chk("t3_e16_fault",     {31'd0, fault},     32'd0);
        17: begin
          chk("t3_e17_fault",     {31'd0, fault},     32'd1);
          chk("t3_e17_reset_out", {28'd0, reset_out}, 32'hE);
          chk("t3_e17_stage",     {30'd0, stage},     32'd1);
        end
        default: ;
      endcase
    end
    chk("t3_fault_sticky", {31'd0, fault}, 32'd1);

    // Reset while fault is set clears it.
    pulse_reset();

    // Loss of ready in RUN, then recovery.
    repeat (20) step(4'hF);
    chk("t4_run_done", {31'd0, done}, 32'd1);
    step(4'b1101);
    chk("t4_drop_reset_out", {28'd0, reset_out}, 32'hE);
    chk("t4_drop_done",      {31'd0, done},      32'd0);
    chk("t4_drop_stage",     {30'd0, stage},     32'd1);
    for (int n = 1; n <= 15; n++) begin
      step(4'hF);
      if (n == 3)  chk("t4_pre_rerelease", {28'd0, reset_out}, 32'hE);
      if (n == 4)  chk("t4_rerelease",     {28'd0, reset_out}, 32'hC);
      if (n == 14) chk("t4_done_low",      {31'd0, done},      32'd0);
      if (n == 15) chk("t4_done_again",    {31'd0, done},      32'd1);
    end

    // Two lower domains drop together while waiting on stage 2.
    pulse_reset();
    repeat (14) step(4'hF);
    chk("t5_stage2", {30'd0, stage}, 32'd2);
    step(4'b1100);
    chk("t5_reset_out", {28'd0, reset_out}, 32'hF);
    chk("t5_stage",     {30'd0, stage},     32'd0);

    // Reset mid-SETTLE, then a full clean sequence.
    pulse_reset();
    repeat (2) step(4'hF);
    pulse_reset();
    for (int n = 1; n <= 20; n++) begin
      step(4'hF);
      if (n == 19) chk("t6_e19_done", {31'd0, done}, 32'd0);
      if (n == 20) chk("t6_e20_done", {31'd0, done}, 32'd1);
    end

    // Randomized ready activity with occasional stuck-low bits and resets.
    stuck_bit  = -1;
    stuck_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) pulse_reset();
      if (stuck_left == 0 && $urandom_range(0, 39) == 0) begin
        stuck_bit  = int'($urandom_range(0, 3));
        stuck_left = int'($urandom_range(4, 12));
      end
      r = 4'hF;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 19) == 0) r[b] = 1'b0;
      if (stuck_left > 0) begin
        r[stuck_bit] = 1'b0;
        stuck_left--;
      end
      step(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
